// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared state codes and select constants for the AES-128 control path
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [5:0] {
        ST_IDLE          = 6'd0,
        ST_PTEXT_WRITE   = 6'd1,
        ST_KEY_WRITE     = 6'd2,
        ST_KEY_EXP_WAIT  = 6'd3,
        ST_INIT_ARK      = 6'd4,
        ST_SUB_BYTES     = 6'd5,
        ST_SHIFT_ROWS    = 6'd6,
        ST_MIX_COLUMNS   = 6'd7,
        ST_ADD_ROUND_KEY = 6'd8,
        ST_WAIT_READ     = 6'd9,
        ST_CTEXT_READ    = 6'd10
    } state_t;

    localparam logic [3:0] SEL_NONE          = 4'd0;
    localparam logic [3:0] SEL_PTEXT         = 4'd1;
    localparam logic [3:0] SEL_KEY           = 4'd2;
    localparam logic [3:0] SEL_SUB_BYTES     = 4'd3;
    localparam logic [3:0] SEL_SHIFT_ROWS    = 4'd4;
    localparam logic [3:0] SEL_MIX_COLUMNS   = 4'd5;
    localparam logic [3:0] SEL_ADD_ROUND_KEY = 4'd6;

    localparam logic MAT_COL   = 1'b0;
    localparam logic MAT_ROW   = 1'b1;
    localparam logic MAT_READ  = 1'b0;
    localparam logic MAT_WRITE = 1'b1;

endpackage

// File: rtl/state_manager.sv
// rtl/state_manager.sv - AES-128 control FSM sequencing load, key expansion wait, ten rounds and read-out
module state_manager
    import aes_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_write_n,
    input  logic       start_read_n,
    input  logic       key_expand_done,
    output logic       done,
    output logic [5:0] dbg_state,
    output logic [3:0] dbg_round,
    output logic [3:0] matrix_in_sel,
    output logic       matrix_write_enable,
    output logic       mat_row_col,
    output logic       mat_read_write,
    output logic [1:0] mat_idx
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     state, state_nx;
    logic [1:0] idx, idx_nx;
    logic [3:0] round, round_nx;
    logic       last_idx;
    logic       stepping;

    always_comb begin
        state_nx = state;
        round_nx = round;
        stepping = 1'b0;
        last_idx = (idx == 2'd3);
        case (state)
            ST_IDLE: begin
                if (!start_write_n) state_nx = ST_PTEXT_WRITE;
            end
            ST_PTEXT_WRITE: begin
                stepping = 1'b1;
                if (last_idx) state_nx = ST_KEY_WRITE;
            end
            ST_KEY_WRITE: begin
                stepping = 1'b1;
                if (last_idx) state_nx = ST_KEY_EXP_WAIT;
            end
            ST_KEY_EXP_WAIT: begin
                if (key_expand_done) begin
                    state_nx = ST_INIT_ARK;
                    round_nx = 4'd0;
                end
            end
            ST_INIT_ARK: begin
                stepping = 1'b1;
                if (last_idx) begin
                    state_nx = ST_SUB_BYTES;
                    round_nx = 4'd1;
                end
            end
            ST_SUB_BYTES: begin
                stepping = 1'b1;
                if (last_idx) state_nx = ST_SHIFT_ROWS;
            end
            // The final round has no MixColumns step
            ST_SHIFT_ROWS: begin
                stepping = 1'b1;
                if (last_idx) state_nx = (round == LAST_ROUND) ? ST_ADD_ROUND_KEY : ST_MIX_COLUMNS;
            end
            ST_MIX_COLUMNS: begin
                stepping = 1'b1;
                if (last_idx) state_nx = ST_ADD_ROUND_KEY;
            end
            ST_ADD_ROUND_KEY: begin
                stepping = 1'b1;
                if (last_idx) begin
                    if (round == LAST_ROUND) begin
                        state_nx = ST_WAIT_READ;
                    end else begin
                        state_nx = ST_SUB_BYTES;
                        round_nx = round + 4'd1;
                    end
                end
            end
            ST_WAIT_READ: begin
                if (!start_read_n) state_nx = ST_CTEXT_READ;
            end
            ST_CTEXT_READ: begin
                stepping = 1'b1;
                if (last_idx) begin
                    state_nx = ST_IDLE;
                    round_nx = 4'd0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                round_nx = 4'd0;
            end
        endcase
        idx_nx = stepping ? idx + 2'd1 : 2'd0;
    end

    // Outputs are decoded from the next-state values so they line up with the state register
    always_ff @(posedge clock) begin
        if (reset_n) begin
            state               <= ST_IDLE;
            idx                 <= 2'd0;
            round               <= 4'd0;
            done                <= 1'b0;
            dbg_state           <= 6'd0;
            dbg_round           <= 4'd0;
            matrix_in_sel       <= SEL_NONE;
            matrix_write_enable <= 1'b0;
            mat_row_col         <= MAT_COL;
            mat_read_write      <= MAT_READ;
            mat_idx             <= 2'd0;
        end else begin
            state               <= state_nx;
            idx                 <= idx_nx;
            round               <= round_nx;
            dbg_state           <= state_nx;
            dbg_round           <= round_nx;
            mat_idx             <= idx_nx;
            done                <= 1'b0;
            matrix_in_sel       <= SEL_NONE;
            matrix_write_enable <= 1'b0;
            mat_row_col         <= MAT_COL;
            mat_read_write      <= MAT_READ;
            case (state_nx)
                ST_PTEXT_WRITE: begin
                    matrix_in_sel       <= SEL_PTEXT;
                    matrix_write_enable <= 1'b1;
                    mat_read_write      <= MAT_WRITE;
                end
                // Key bytes go to the expander's storage, not into the state matrix
                ST_KEY_WRITE: begin
                    matrix_in_sel  <= SEL_KEY;
                    mat_read_write <= MAT_WRITE;
                end
                ST_INIT_ARK, ST_ADD_ROUND_KEY: begin
                    matrix_in_sel       <= SEL_ADD_ROUND_KEY;
                    matrix_write_enable <= 1'b1;
                    mat_read_write      <= MAT_WRITE;
                end
                ST_SUB_BYTES: begin
                    matrix_in_sel       <= SEL_SUB_BYTES;
                    matrix_write_enable <= 1'b1;
                    mat_read_write      <= MAT_WRITE;
                end
                ST_SHIFT_ROWS: begin
                    matrix_in_sel       <= SEL_SHIFT_ROWS;
                    matrix_write_enable <= 1'b1;
                    mat_row_col         <= MAT_ROW;
                    mat_read_write      <= MAT_WRITE;
                end
                ST_MIX_COLUMNS: begin
                    matrix_in_sel       <= SEL_MIX_COLUMNS;
                    matrix_write_enable <= 1'b1;
                    mat_read_write      <= MAT_WRITE;
                end
                ST_WAIT_READ, ST_CTEXT_READ: begin
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_manager.sv
// tb/tb_state_manager.sv - self-checking bench for state_manager against a phase-list reference model
module tb_state_manager;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start_write_n;
    logic       start_read_n;
    logic       key_expand_done;
    logic       done;
    logic [5:0] dbg_state;
    logic [3:0] dbg_round;
    logic [3:0] matrix_in_sel;
    logic       matrix_write_enable;
    logic       mat_row_col;
    logic       mat_read_write;
    logic [1:0] mat_idx;

    state_manager dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .start_write_n       (start_write_n),
        .start_read_n        (start_read_n),
        .key_expand_done     (key_expand_done),
        .done                (done),
        .dbg_state           (dbg_state),
        .dbg_round           (dbg_round),
        .matrix_in_sel       (matrix_in_sel),
        .matrix_write_enable (matrix_write_enable),
        .mat_row_col         (mat_row_col),
        .mat_read_write      (mat_read_write),
        .mat_idx             (mat_idx)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int abort_in = -1;
    bit aborted = 1'b0;
    int cnt_sr, cnt_mc, cnt_ark;
    int t_ark, t_done;

    logic [19:0] obs;
    assign obs = {done, dbg_state, dbg_round, matrix_in_sel, matrix_write_enable,
                  mat_row_col, mat_read_write, mat_idx};

    function automatic logic [19:0] vec(input logic d, input logic [5:0] st, input logic [3:0] rnd,
                                        input logic [3:0] sel, input logic we, input logic rc,
                                        input logic rw, input logic [1:0] idx);
        return {d, st, rnd, sel, we, rc, rw, idx};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (dbg_state == 6'd6) cnt_sr++;
        if (dbg_state == 6'd7) cnt_mc++;
        if (dbg_state == 6'd4 || dbg_state == 6'd8) cnt_ark++;
        if (dbg_state == 6'd4 && t_ark < 0) t_ark = cyc;
        if (done && t_done < 0) t_done = cyc;
    endtask

    task automatic check(input string tag, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Strobes that the current state must ignore
    task automatic noise();
        start_write_n   = 1'($urandom_range(0, 1));
        start_read_n    = 1'($urandom_range(0, 1));
        key_expand_done = 1'($urandom_range(0, 1));
    endtask

    task automatic phase(input string tag, input logic [5:0] st, input logic [3:0] sel, input logic we,
                         input logic rc, input logic rw, input logic [3:0] rnd, input logic d);
        for (int i = 0; i < 4; i++) begin
            if (aborted) return;
            if (abort_in == 0) begin
                reset_n = 1'b1;
                step();
                check({tag, "_reset"}, 20'h0);
                reset_n = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (abort_in > 0) abort_in--;
            step();
            check(tag, vec(d, st, rnd, sel, we, rc, rw, 2'(i)));
            noise();
        end
    endtask

    task automatic quiet_idle_check(input string tag);
        start_write_n = 1'b1;
        step();
        check(tag, 20'h0);
    endtask

    task automatic full_run(input int pre_idle, input int exp_wait, input int rd_wait,
                            input int abort_at, input bit both_low);
        aborted  = 1'b0;
        abort_in = abort_at;
        cnt_sr = 0; cnt_mc = 0; cnt_ark = 0;
        t_ark = -1; t_done = -1;
        start_write_n = 1'b1;
        for (int i = 0; i < pre_idle; i++) begin
            start_read_n    = 1'($urandom_range(0, 1));
            key_expand_done = 1'($urandom_range(0, 1));
            step();
            check("idle_hold", 20'h0);
        end
        start_write_n = 1'b0;
        start_read_n  = both_low ? 1'b0 : 1'b1;
        phase("ptext", 6'd1, 4'd1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        phase("key",   6'd2, 4'd2, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        if (aborted) begin quiet_idle_check("post_abort_idle"); return; end
        key_expand_done = 1'b0;
        for (int i = 0; i < exp_wait; i++) begin
            step();
            check("kexp_wait", vec(1'b0, 6'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0));
            start_write_n = 1'($urandom_range(0, 1));
            start_read_n  = 1'($urandom_range(0, 1));
        end
        key_expand_done = 1'b1;
        phase("init_ark", 6'd4, 4'd6, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        for (int r = 1; r <= 10; r++) begin
            phase("sub_bytes",  6'd5, 4'd3, 1'b1, 1'b0, 1'b1, 4'(r), 1'b0);
            phase("shift_rows", 6'd6, 4'd4, 1'b1, 1'b1, 1'b1, 4'(r), 1'b0);
            if (r < 10) phase("mix_columns", 6'd7, 4'd5, 1'b1, 1'b0, 1'b1, 4'(r), 1'b0);
            phase("add_round_key", 6'd8, 4'd6, 1'b1, 1'b0, 1'b1, 4'(r), 1'b0);
        end
        if (aborted) begin quiet_idle_check("post_abort_idle"); return; end
        start_read_n = 1'b1;
        for (int i = 0; i < rd_wait; i++) begin
            step();
            check("wait_read", vec(1'b1, 6'd9, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0));
            start_write_n   = 1'($urandom_range(0, 1));
            key_expand_done = 1'($urandom_range(0, 1));
        end
        check_int("cipher_latency", t_done - t_ark, 4 + 9 * 16 + 12);
        check_int("shift_rows_cycles", cnt_sr, 10 * 4);
        check_int("mix_columns_cycles", cnt_mc, 9 * 4);
        check_int("add_round_key_cycles", cnt_ark, 11 * 4);
        start_read_n = 1'b0;
        phase("ctext_read", 6'd10, 4'd0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b1);
        start_read_n = 1'b1;
        quiet_idle_check("idle_after_read");
    endtask

    initial begin
        reset_n         = 1'b1;
        start_write_n   = 1'b1;
        start_read_n    = 1'b1;
        key_expand_done = 1'b0;
        step();
        check("reset_c1", 20'h0);
        step();
        check("reset_c2", 20'h0);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_no_strobe", 20'h0);
        end

        full_run(2, 5, 3, -1, 1'b1);
        full_run(1, 1, 1, -1, 1'b0);
        // Reset while in MixColumns of round 5, index 2
        full_run(2, 1, 1, 8 + 4 + 4 * 16 + 8 + 2, 1'b0);
        full_run(0, 3, 2, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            full_run($urandom_range(0, 4), $urandom_range(1, 12), $urandom_range(1, 6),
                     (k == 1) ? $urandom_range(0, 167) : -1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/state_manager.md
# state_manager

Control FSM of the AES-128 encryption core. It sequences plaintext and key loading, waits for key expansion, then steps the 4x4 state matrix through the initial AddRoundKey and ten cipher rounds one column or row per cycle. It finally exposes the ciphertext for a four-cycle read-out. It drives only select, enable and index lines to the state-matrix datapath; it holds no data.

## Interface
- No parameters.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-high reset; asserted = 1, despite the codebase name.
- start_write_n  in  1  active-low start of plaintext/key load; sampled only in IDLE.
- start_read_n  in  1  active-low start of ciphertext read-out; sampled only in WAIT_READ.
- key_expand_done  in  1  level from key expander; sampled only in KEY_EXP_WAIT.
- done  out  1  ciphertext ready; high in WAIT_READ and CTEXT_READ.
- dbg_state  out  6  current state encoding.
- dbg_round  out  4  current round, 0..10.
- matrix_in_sel  out  4  matrix write-source select: 0 none, 1 PTEXT, 2 KEY, 3 SUB_BYTES, 4 SHIFT_ROWS, 5 MIX_COLUMNS, 6 ADD_ROUND_KEY.
- matrix_write_enable  out  1  state-matrix write strobe.
- mat_row_col  out  1  0 = column access, 1 = row access.
- mat_read_write  out  1  1 = write, 0 = read.
- mat_idx  out  2  row/column index 0..3.

## Operation
- States and dbg_state codes:
  - IDLE 0
  - PTEXT_WRITE 1
  - KEY_WRITE 2
  - KEY_EXP_WAIT 3
  - INIT_ARK 4
  - SUB_BYTES 5
  - SHIFT_ROWS 6
  - MIX_COLUMNS 7
  - ADD_ROUND_KEY 8
  - WAIT_READ 9
  - CTEXT_READ 10
- All outputs are Moore, decoded from the state register, the 2-bit index counter and the 4-bit round counter.
- Every 4-cycle state steps mat_idx 0,1,2,3 and then advances.
- IDLE: all outputs 0. start_write_n==0 at an edge → PTEXT_WRITE.
- PTEXT_WRITE: sel=1, we=1, col, write.
- KEY_WRITE: sel=2, we=0 (key routed to expander storage), col, write.
- KEY_EXP_WAIT: outputs idle. Stays here until key_expand_done==1, then → INIT_ARK with round=0.
- INIT_ARK: sel=6, we=1, col. Then round←1 → SUB_BYTES.
- SUB_BYTES: sel=3, we=1, col.
- SHIFT_ROWS: sel=4, we=1, row (mat_row_col=1).
- After SHIFT_ROWS: round<10 → MIX_COLUMNS; round==10 → ADD_ROUND_KEY (MixColumns skipped).
- MIX_COLUMNS: sel=5, we=1, col.
- ADD_ROUND_KEY: sel=6, we=1, col. Then round<10 → round+1, SUB_BYTES; round==10 → WAIT_READ.
- WAIT_READ: done=1, dbg_round=10. start_read_n==0 → CTEXT_READ.
- CTEXT_READ: done=1, we=0, read (mat_read_write=0), col idx 0..3. Then → IDLE, round←0.
- Start strobes are ignored outside their sampling state. Both strobes low in IDLE: write wins.
- A key_expand_done pulse outside KEY_EXP_WAIT is ignored. The expander must hold it high or assert it after entry.

## Timing
- Reset: state IDLE, idx 0, round 0; every output 0, including dbg_state=0.
- Reset during any state returns to IDLE on the next edge and aborts the operation.
- Start latency: strobe sampled at edge E0 → PTEXT_WRITE from E0 onward, idx 0.
- Load: 8 cycles (PTEXT_WRITE 4, KEY_WRITE 4), then KEY_EXP_WAIT for at least 1 cycle.
- Cipher: exactly 160 cycles from INIT_ARK entry to WAIT_READ entry:
  - INIT_ARK 4
  - rounds 1–9: 16 each
  - round 10: 12
- Read-out: 4 cycles, then IDLE. done falls on entry to IDLE.
- mat_idx wraps 3→0 on every state change. The counter is 2 bits, so no overflow handling is needed.

## Structure
- Shared package aes_pkg holds:
  - state enum (6-bit) with the codes above
  - matrix_in_sel constants
  - NUM_ROUNDS=10
  - ROW/COL and READ/WRITE bit constants
- Single module. No sub-module: next-state logic, counters and output decode total about 150–250 lines.

## Test plan
- Reset held 2 cycles → all outputs 0, dbg_state=0. Release with no strobe → remains IDLE.
- start_write_n low for one edge → dbg_state 1 for 4 cycles with mat_idx 0..3, sel=1, we=1. Then state 2 for 4 cycles with we=0. Then state 3, held indefinitely without key_expand_done.
- key_expand_done pulse in state 3 → state 4 next. done rises exactly 160 cycles later. dbg_round steps 0..10. State 7 never appears while dbg_round=10.
- Check SHIFT_ROWS: mat_row_col=1 for 4 cycles per round. Check count: 10 SHIFT_ROWS, 9 MIX_COLUMNS, and 11 ADD_ROUND_KEY phases including INIT_ARK.
- In WAIT_READ, pulse start_read_n → state 10 for 4 cycles with mat_read_write=0, we=0, idx 0..3. Then IDLE with done=0.
- Assert reset mid-round (e.g. state 7, round 5) → next cycle IDLE, round 0, outputs 0. A subsequent full run still takes 160 cycles.
